// File: rtl/fp_add_sub_pipe_if.sv
// Valid/ready operand and result channels of the pipelined FP add/sub core.
interface fp_add_sub_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       flags;

    modport master (
        output in_valid, a, b, op, in_tag, out_ready,
        input  in_ready, out_valid, r, out_tag, flags
    );

    modport slave (
        input  in_valid, a, b, op, in_tag, out_ready,
        output in_ready, out_valid, r, out_tag, flags
    );
endinterface

// File: rtl/fp_add_sub_pipe.sv
// Parametrised IEEE-754 add/subtract, 5-stage valid/ready pipeline.
// FTZ inputs, RNE rounding, specials resolved up front and carried.
module fp_add_sub_pipe #(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int WIDTH     = 1 + EXP_BITS + MANT_BITS,
    parameter int TAG_W     = 4
) (
    input logic               clk,
    input logic               rst,
    fp_add_sub_pipe_if.slave  io
);
    localparam int E     = EXP_BITS;
    localparam int M     = MANT_BITS;
    localparam int MW    = M + 4;
    localparam int SHMAX = M + 3;
    localparam logic [E-1:0] EMAX = '1;
    localparam logic [WIDTH-1:0] QNAN = {1'b0, EMAX, 1'b1, {(M-1){1'b0}}};

    typedef struct packed {
        logic             sp;
        logic [WIDTH-1:0] sp_r;
        logic [2:0]       sp_f;
        logic             sgn;
        logic [TAG_W-1:0] tag;
    } ctl_t;

    typedef struct packed {
        ctl_t       c;
        logic       sub;
        logic [E-1:0] ex;
        logic [E-1:0] d;
        logic [M:0] mx;
        logic [M:0] my;
    } s1_t;

    typedef struct packed {
        ctl_t          c;
        logic          sub;
        logic [E-1:0]  ex;
        logic [M:0]    mx;
        logic [MW-1:0] my;
    } s2_t;

    typedef struct packed {
        ctl_t         c;
        logic [E-1:0] ex;
        logic [MW:0]  sum;
    } s3_t;

    typedef struct packed {
        ctl_t          c;
        logic          zero;
        logic          uf;
        logic [E:0]    xn;
        logic [MW-1:0] mn;
    } s4_t;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] tag;
        logic [2:0]       flags;
    } s5_t;

    logic [4:0] vld;
    logic       stall;
    s1_t s1, s1_d;
    s2_t s2, s2_d;
    s3_t s3, s3_d;
    s4_t s4, s4_d;
    s5_t s5, s5_d;

    assign stall        = vld[4] & ~io.out_ready;
    assign io.in_ready  = ~stall;
    assign io.out_valid = vld[4];
    assign io.r         = s5.r;
    assign io.out_tag   = s5.tag;
    assign io.flags     = s5.flags;

    // S1: unpack, classify, order operands so |X| >= |Y|
    logic           sa, sb, za, zb, na, nb, ia, ib, swap;
    logic [E-1:0]   ea, eb;
    logic [M-1:0]   fa, fb;
    logic [E+M-1:0] mag_a, mag_b;

    always_comb begin
        sa    = io.a[WIDTH-1];
        ea    = io.a[WIDTH-2 -: E];
        fa    = io.a[M-1:0];
        sb    = io.b[WIDTH-1] ^ io.op;
        eb    = io.b[WIDTH-2 -: E];
        fb    = io.b[M-1:0];
        za    = (ea == '0);
        zb    = (eb == '0);
        ia    = (ea == EMAX) && (fa == '0);
        ib    = (eb == EMAX) && (fb == '0);
        na    = (ea == EMAX) && (fa != '0);
        nb    = (eb == EMAX) && (fb != '0);
        mag_a = za ? '0 : {ea, fa};
        mag_b = zb ? '0 : {eb, fb};
        swap  = mag_b > mag_a;

        s1_d       = '0;
        s1_d.c.tag = io.in_tag;
        s1_d.c.sgn = swap ? sb : sa;
        s1_d.sub   = sa != sb;
        s1_d.ex    = swap ? eb : ea;
        s1_d.d     = swap ? eb - ea : ea - eb;
        s1_d.mx    = swap ? (zb ? '0 : {1'b1, fb})
                          : (za ? '0 : {1'b1, fa});
        s1_d.my    = swap ? (za ? '0 : {1'b1, fa})
                          : (zb ? '0 : {1'b1, fb});

        if (na || nb) begin
            s1_d.c.sp   = 1'b1;
            s1_d.c.sp_r = QNAN;
        end else if (ia && ib && (sa != sb)) begin
            s1_d.c.sp   = 1'b1;
            s1_d.c.sp_r = QNAN;
            s1_d.c.sp_f = 3'b100;
        end else if (ia || ib) begin
            s1_d.c.sp   = 1'b1;
            s1_d.c.sp_r = {ia ? sa : sb, EMAX, {M{1'b0}}};
        end else if (za && zb) begin
            s1_d.c.sp   = 1'b1;
            s1_d.c.sp_r = {sa & sb, {(WIDTH-1){1'b0}}};
        end
    end

    // S2: right-align Y with guard/round and a sticky LSB
    int               sh;
    logic [2*MW-1:0]  wide;

    always_comb begin
        sh      = (int'(s1.d) > SHMAX) ? SHMAX : int'(s1.d);
        wide    = {s1.my, 3'b000, {MW{1'b0}}} >> sh;
        s2_d    = '0;
        s2_d.c  = s1.c;
        s2_d.sub = s1.sub;
        s2_d.ex = s1.ex;
        s2_d.mx = s1.mx;
        s2_d.my = wide[2*MW-1:MW] | {{(MW-1){1'b0}}, |wide[MW-1:0]};
    end

    // S3: magnitude add/subtract
    always_comb begin
        s3_d     = '0;
        s3_d.c   = s2.c;
        s3_d.ex  = s2.ex;
        s3_d.sum = s2.sub ? ({1'b0, s2.mx, 3'b000} - {1'b0, s2.my})
                          : ({1'b0, s2.mx, 3'b000} + {1'b0, s2.my});
    end

    // S4: leading-zero count and normalise
    int lz;
    int xi;

    always_comb begin
        lz = MW;
        for (int i = 0; i < MW; i++) begin
            if (s3.sum[i]) lz = MW - 1 - i;
        end
        s4_d   = '0;
        s4_d.c = s3.c;
        if (s3.sum[MW]) begin
            s4_d.mn = {s3.sum[MW:2], s3.sum[1] | s3.sum[0]};
            xi      = int'(s3.ex) + 1;
        end else begin
            s4_d.mn = s3.sum[MW-1:0] << lz;
            xi      = int'(s3.ex) - lz;
        end
        s4_d.zero = (s3.sum == '0);
        s4_d.uf   = !s4_d.zero && (xi < 1);
        s4_d.xn   = (E+1)'(xi);
    end

    // S5: round to nearest even, then pack with overflow/underflow
    logic         inc, of;
    logic [M+1:0] rnd;
    logic [E:0]   xr;
    logic [M-1:0] frac;

    always_comb begin
        inc = s4.mn[2] & (s4.mn[1] | s4.mn[0] | s4.mn[3]);
        rnd = {1'b0, s4.mn[MW-1:3]} + {{(M+1){1'b0}}, inc};
        if (rnd[M+1]) begin
            xr   = s4.xn + {{E{1'b0}}, 1'b1};
            frac = rnd[M:1];
        end else begin
            xr   = s4.xn;
            frac = rnd[M-1:0];
        end
        of = xr >= {1'b0, EMAX};

        s5_d     = '0;
        s5_d.tag = s4.c.tag;
        if (s4.c.sp) begin
            s5_d.r     = s4.c.sp_r;
            s5_d.flags = s4.c.sp_f;
        end else if (s4.zero) begin
            s5_d.r = '0;
        end else if (s4.uf) begin
            s5_d.r     = {s4.c.sgn, {(WIDTH-1){1'b0}}};
            s5_d.flags = 3'b001;
        end else if (of) begin
            s5_d.r     = {s4.c.sgn, EMAX, {M{1'b0}}};
            s5_d.flags = 3'b010;
        end else begin
            s5_d.r = {s4.c.sgn, xr[E-1:0], frac};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            s1  <= '0;
            s2  <= '0;
            s3  <= '0;
            s4  <= '0;
            s5  <= '0;
        end else if (!stall) begin
            vld <= {vld[3:0], io.in_valid};
            s1  <= s1_d;
            s2  <= s2_d;
            s3  <= s3_d;
            s4  <= s4_d;
            s5  <= s5_d;
        end
    end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Bench for fp_add_sub_pipe: exact-arithmetic reference model with a
// scoreboard, directed corner vectors, stall, reset-flush and random traffic.
module tb_fp_add_sub_pipe;
    localparam int E  = 8;
    localparam int M  = 23;
    localparam int W  = 32;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_add_sub_pipe_if #(.WIDTH(W), .TAG_W(TW)) io ();

    fp_add_sub_pipe #(
        .EXP_BITS(E), .MANT_BITS(M), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .io(io)
    );

    typedef struct {
        logic [31:0] r;
        logic [2:0]  f;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   delivered = 0;
    bit   lat_mode  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact value of each operand as an integer in units of 2^(1-bias-M),
    // summed without loss and then rounded once.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic op, output logic [31:0] r,
                                  output logic [2:0] f);
        logic sa, sb, s, na, nb, ia, ib;
        int ea, eb, en, p, sh;
        logic [22:0] fa, fb;
        logic [299:0] ma, mb, mag, keep, rem, half;
        sa = a[31]; ea = int'(a[30:23]); fa = a[22:0];
        sb = b[31] ^ op; eb = int'(b[30:23]); fb = b[22:0];
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        f = 3'b000;
        r = 32'h0;
        if (na || nb) begin r = 32'h7FC00000; return; end
        if (ia && ib && sa != sb) begin
            r = 32'h7FC00000; f = 3'b100; return;
        end
        if (ia) begin r = {sa, 8'hFF, 23'h0}; return; end
        if (ib) begin r = {sb, 8'hFF, 23'h0}; return; end
        ma = (ea == 0) ? '0 : (300'({1'b1, fa}) << (ea - 1));
        mb = (eb == 0) ? '0 : (300'({1'b1, fb}) << (eb - 1));
        if (ma == 0 && mb == 0) begin r = {sa & sb, 31'h0}; return; end
        if (sa == sb) begin mag = ma + mb; s = sa; end
        else if (ma > mb) begin mag = ma - mb; s = sa; end
        else if (mb > ma) begin mag = mb - ma; s = sb; end
        else begin r = 32'h0; return; end
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        en = p - M + 1;
        if (en < 1) begin r = {s, 31'h0}; f = 3'b001; return; end
        sh = p - M;
        keep = mag >> sh;
        rem = mag - (keep << sh);
        if (sh > 0) begin
            half = 300'(1) << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 1;
        end
        if (keep[M+1]) begin keep = keep >> 1; en++; end
        if (en >= 255) begin r = {s, 8'hFF, 23'h0}; f = 3'b010; return; end
        r = {s, en[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] pick_special();
        logic [31:0] t[9] = '{32'h00000000, 32'h80000000, 32'h7F800000,
                              32'hFF800000, 32'h7FC00000, 32'h7F800123,
                              32'h00012345, 32'h7F7FFFFF, 32'h00800000};
        return t[$urandom_range(0, 8)];
    endfunction

    function automatic void gen(output logic [31:0] a, output logic [31:0] b);
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 5))
            0: ;
            1: b[30:23] = a[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
            2: b = a ^ 32'($urandom_range(0, 15));
            3: b = pick_special();
            4: begin
                a = {1'($urandom), 8'($urandom_range(1, 3)), 23'($urandom)};
                b = a ^ 32'($urandom_range(0, 255));
            end
            default: a = pick_special();
        endcase
    endfunction

    task automatic tick(input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic op,
                        input logic [3:0] tag, input logic ordy,
                        input logic dir, input logic [31:0] er,
                        input logic [2:0] ef, output logic acc);
        exp_t e;
        logic [31:0] mr;
        logic [2:0] mf;
        io.in_valid  = v;
        io.a         = a;
        io.b         = b;
        io.op        = op;
        io.in_tag    = tag;
        io.out_ready = ordy;
        #1;
        acc = v && io.in_ready && !rst;
        if (acc) begin
            model(a, b, op, mr, mf);
            e.r   = dir ? er : mr;
            e.f   = dir ? ef : mf;
            e.tag = tag;
            e.cyc = cyc;
            q.push_back(e);
        end
        if (!rst) begin
            if (io.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'(io.out_valid), 32'd0);
                end else if (ordy) begin
                    e = q.pop_front();
                    chk("r", io.r, e.r);
                    chk("flags", 32'(io.flags), 32'(e.f));
                    chk("tag", 32'(io.out_tag), 32'(e.tag));
                    if (lat_mode) chk("latency", 32'(cyc - e.cyc), 32'd5);
                    delivered++;
                end else begin
                    chk("in_ready_stall", 32'(io.in_ready), 32'd0);
                end
            end else if (lat_mode && q.size() > 0 && cyc - q[0].cyc >= 5) begin
                chk("late_valid", 32'(io.out_valid), 32'd1);
            end
        end
        @(posedge clk);
        if (rst) q.delete();
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 60 && q.size() > 0; i++)
            tick(0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        op;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    vec_t dv[13] = '{
        '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000},
        '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000},
        '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010},
        '{32'h00800000, 32'h00800000, 1'b1, 32'h00000000, 3'b000},
        '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001},
        '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000},
        '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000},
        '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000},
        '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000},
        '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000},
        '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000},
        '{32'h00400000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000}
    };

    initial begin
        logic acc;
        logic [31:0] a, b;
        int t, n;
        rst = 1'b1;
        io.in_valid = 0; io.a = 0; io.b = 0; io.op = 0;
        io.in_tag = 0; io.out_ready = 1;
        @(negedge clk);
        tick(0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
        tick(0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_r", io.r, 32'd0);
        chk("rst_out_tag", 32'(io.out_tag), 32'd0);
        chk("rst_flags", 32'(io.flags), 32'd0);
        chk("rst_in_ready", 32'(io.in_ready), 32'd1);
        @(negedge clk);

        lat_mode = 1;
        for (int i = 0; i < 13; i++)
            tick(1, dv[i].a, dv[i].b, dv[i].op, 4'(i), 1, 1,
                 dv[i].r, dv[i].f, acc);
        drain();

        lat_mode = 0;
        n = delivered;
        t = 0;
        for (int i = 0; i < 50 && t < 8; i++) begin
            gen(a, b);
            tick(1, a, b, 1'($urandom), 4'(t), !(i >= 6 && i < 9),
                 0, 0, 0, acc);
            if (acc) t++;
        end
        drain();
        chk("t5_count", 32'(delivered - n), 32'd8);

        lat_mode = 1;
        for (int i = 0; i < 3; i++) begin
            gen(a, b);
            tick(1, a, b, 0, 4'(i), 1, 0, 0, 0, acc);
        end
        rst = 1'b1;
        tick(0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
            chk("t6_quiet", 32'(io.out_valid), 32'd0);
        end
        tick(1, 32'h3F800000, 32'h40000000, 0, 4'hA, 1, 1,
             32'h40400000, 3'b000, acc);
        drain();

        lat_mode = 0;
        for (int i = 0; i < 2000; i++) begin
            gen(a, b);
            tick(($urandom % 4) != 0, a, b, 1'($urandom), 4'($urandom),
                 ($urandom % 4) != 0, 0, 0, 0, acc);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
